swd_xfer_ctl: RTL and testbench

- Transaction sequencer that sits between the debug command layer and the SWD line engine (swdIF).
- Accepts one DP/AP register transfer at a time and launches the frame using swdIF's go/idle protocol.
- Retries on WAIT acknowledgements, up to a configurable limit.
- For AP reads, automatically follows with a DP RDBUFF read, because SWD AP reads return posted data. Reports a single status and data word per request.

---
 rtl/swd_xfer_ctl.sv | 195 +++++++++++++++++++
 tb/tb_swd_xfer_ctl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swd_xfer_ctl.sv
// swd_xfer_ctl: SWD transaction sequencer between the debug command layer and
// the swdIF line engine. It runs one DP/AP register transfer at a time and
// re-issues a frame on a WAIT acknowledge, up to a retry limit. An AP read is
// automatically followed by a DP RDBUFF read, because AP read data is posted.
// Each request gets exactly one response pulse.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   cfg_retries         WAIT retry limit (0 selects WAIT_RETRIES)
//   req_*               request handshake and transfer fields
//   rsp_*               response pulse, status, read data, WAIT retries used
//   swd_addr32/apndp/rnw/dwrite/go   frame fields and launch strobe to swdIF
//   swd_idle/ack/dread/perr          frame status and results from swdIF
//
// state  | meaning
// IDLE   | waiting for a request (accepted only while swdIF is idle)
// LAUNCH | go held high until swdIF leaves idle
// BUSY   | frame in flight, waiting for swdIF to return to idle
// EVAL   | one cycle to decode ack: retry, chain RDBUFF or finish
// DONE   | one-cycle response pulse
module swd_xfer_ctl #(
    parameter logic [7:0]  WAIT_RETRIES = 8'd32,
    parameter int unsigned TIMEOUT_CYC  = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cfg_retries,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_addr,
    input  logic        req_apndp,
    input  logic        req_rnw,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [2:0]  rsp_status,
    output logic [31:0] rsp_rdata,
    output logic [7:0]  rsp_retries,
    output logic [1:0]  swd_addr32,
    output logic        swd_apndp,
    output logic        swd_rnw,
    output logic [31:0] swd_dwrite,
    output logic        swd_go,
    input  logic        swd_idle,
    input  logic [2:0]  swd_ack,
    input  logic [31:0] swd_dread,
    input  logic        swd_perr
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_BUSY   = 3'd2;
    localparam logic [2:0] S_EVAL   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam logic [2:0] ST_OK       = 3'd0;
    localparam logic [2:0] ST_WAIT_EXH = 3'd1;
    localparam logic [2:0] ST_FAULT    = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_PROTOCOL = 3'd4;
    localparam logic [2:0] ST_TIMEOUT  = 3'd5;

    localparam logic [TIMEOUT_CYC-1:0] WD_ONE = {{(TIMEOUT_CYC-1){1'b0}}, 1'b1};

    logic [2:0]             state_q, state_d, status_d;
    logic [TIMEOUT_CYC-1:0] wdog_q;
    logic [7:0]             retry_q, limit;
    logic                   rdbuff_q, accept, wdog_tc, wait_more;
    logic                   swd_go_q, rsp_valid_q, swd_apndp_q, swd_rnw_q;
    logic [1:0]             swd_addr32_q;
    logic [31:0]            swd_dwrite_q, rsp_rdata_q;
    logic [2:0]             rsp_status_q;
    logic [7:0]             rsp_retries_q;

    // rst_n gates ready so every output reads 0 while reset is held.
    assign req_ready   = rst_n && (state_q == S_IDLE) && swd_idle;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_retries = rsp_retries_q;
    assign swd_addr32  = swd_addr32_q;
    assign swd_apndp   = swd_apndp_q;
    assign swd_rnw     = swd_rnw_q;
    assign swd_dwrite  = swd_dwrite_q;
    assign swd_go      = swd_go_q;

    always_comb begin
        limit     = (cfg_retries == 8'd0) ? WAIT_RETRIES : cfg_retries;
        accept    = req_valid && req_ready;
        // Watchdog loads all-ones and stops at 1, giving the frame
        // exactly 2^TIMEOUT_CYC-1 cycles in LAUNCH/BUSY.
        wdog_tc   = (wdog_q == WD_ONE);
        wait_more = (retry_q < limit);
        state_d   = state_q;
        status_d  = ST_OK;
        case (state_q)
            S_IDLE: if (accept) state_d = S_LAUNCH;
            S_LAUNCH: begin
                if (wdog_tc) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end else if (!swd_idle) begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (wdog_tc) begin
                    status_d = ST_TIMEOUT;
                    state_d  = S_DONE;
                end else if (swd_idle) begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d = S_DONE;
                if (swd_ack == ACK_WAIT) begin
                    if (wait_more) state_d = S_LAUNCH;
                    else           status_d = ST_WAIT_EXH;
                end else if (swd_ack == ACK_FAULT) begin
                    status_d = ST_FAULT;
                end else if (swd_ack != ACK_OK) begin
                    status_d = ST_PROTOCOL;
                end else if (swd_rnw_q && swd_perr) begin
                    status_d = ST_PARITY;
                end else if (rdbuff_q) begin
                    state_d = S_LAUNCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wdog_q        <= '0;
            retry_q       <= 8'd0;
            rdbuff_q      <= 1'b0;
            swd_go_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
            swd_addr32_q  <= 2'b00;
            swd_apndp_q   <= 1'b0;
            swd_rnw_q     <= 1'b0;
            swd_dwrite_q  <= 32'd0;
            rsp_rdata_q   <= 32'd0;
            rsp_status_q  <= 3'd0;
            rsp_retries_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            swd_go_q    <= (state_d == S_LAUNCH);
            rsp_valid_q <= (state_d == S_DONE);

            if (state_d == S_LAUNCH && state_q != S_LAUNCH) begin
                wdog_q <= '1;
            end else if ((state_q == S_LAUNCH || state_q == S_BUSY) && !wdog_tc) begin
                wdog_q <= wdog_q - WD_ONE;
            end

            if (accept) begin
                swd_addr32_q <= req_addr;
                swd_apndp_q  <= req_apndp;
                swd_rnw_q    <= req_rnw;
                swd_dwrite_q <= req_wdata;
                retry_q      <= 8'd0;
                rdbuff_q     <= req_apndp & req_rnw;
            end

            if (state_q == S_EVAL) begin
                if (swd_ack == ACK_WAIT && wait_more && retry_q != 8'hFF) begin
                    retry_q <= retry_q + 8'd1;
                end
                // OK ack going back to LAUNCH is the posted-read follow-up.
                if (state_d == S_LAUNCH && swd_ack == ACK_OK) begin
                    rdbuff_q     <= 1'b0;
                    swd_addr32_q <= 2'b11;
                    swd_apndp_q  <= 1'b0;
                    swd_rnw_q    <= 1'b1;
                end
                if (state_d == S_DONE && status_d == ST_OK && swd_rnw_q) begin
                    rsp_rdata_q <= swd_dread;
                end
            end

            if (state_d == S_DONE) begin
                rsp_status_q  <= status_d;
                rsp_retries_q <= retry_q;
            end
        end
    end

endmodule

// File: tb/tb_swd_xfer_ctl.sv
module tb_swd_xfer_ctl;

    typedef struct packed {
        logic [2:0]  ack;
        logic [31:0] dread;
        logic        perr;
    } resp_t;

    typedef struct packed {
        logic [1:0]  addr;
        logic        apndp;
        logic        rnw;
        logic [31:0] wdata;
    } frame_t;

    localparam resp_t DEF_RESP = '{3'b001, 32'hCAFE_F00D, 1'b0};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_retries;
    logic        req_valid, req_ready, req_apndp, req_rnw;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [2:0]  rsp_status;
    logic [31:0] rsp_rdata;
    logic [7:0]  rsp_retries;
    logic [1:0]  swd_addr32;
    logic        swd_apndp, swd_rnw, swd_go, swd_idle, swd_perr;
    logic [31:0] swd_dwrite, swd_dread;
    logic [2:0]  swd_ack;

    swd_xfer_ctl #(.WAIT_RETRIES(8'd32), .TIMEOUT_CYC(6)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_retries(cfg_retries),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_apndp(req_apndp), .req_rnw(req_rnw), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
        .rsp_retries(rsp_retries), .swd_addr32(swd_addr32), .swd_apndp(swd_apndp),
        .swd_rnw(swd_rnw), .swd_dwrite(swd_dwrite), .swd_go(swd_go),
        .swd_idle(swd_idle), .swd_ack(swd_ack), .swd_dread(swd_dread),
        .swd_perr(swd_perr)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_pass = 0;
    resp_t  scr[$];       // per-frame engine responses, indexed by frame number
    frame_t obs[$];       // frames seen by the engine
    logic   go_after[$];  // swd_go one clock after idle fell, per frame
    frame_t expf[$];
    logic [31:0] exp_rdata = 32'd0;
    bit     stuck = 0;
    bit     hold = 0;
    int     rsp_cnt = 0;
    time    t_rise = 0;
    time    t_fall = 0;
    int     base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    always @(posedge swd_go) t_rise = $time;
    always @(negedge swd_go) t_fall = $time;

    // swdIF model: starts a frame some cycles after seeing go, runs it, then
    // returns idle with the scripted response for that frame number.
    initial begin : engine
        frame_t f;
        resp_t  r;
        int     idx;
        logic   g;
        swd_idle = 1'b1; swd_ack = 3'b000; swd_dread = 32'd0; swd_perr = 1'b0;
        forever begin
            @(negedge clk);
            if (swd_go && !stuck) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                f = '{swd_addr32, swd_apndp, swd_rnw, swd_dwrite};
                swd_idle = 1'b0;
                @(negedge clk);
                g = swd_go;
                idx = obs.size();
                obs.push_back(f);
                go_after.push_back(g);
                repeat ($urandom_range(0, 4)) @(negedge clk);
                while (hold) @(negedge clk);
                r = (idx < scr.size()) ? scr[idx] : DEF_RESP;
                swd_ack = r.ack; swd_dread = r.dread; swd_perr = r.perr;
                swd_idle = 1'b1;
            end
        end
    end

    // Align the response script with the engine's next frame number.
    task automatic begin_req();
        while (scr.size() > obs.size()) void'(scr.pop_back());
        while (scr.size() < obs.size()) scr.push_back(DEF_RESP);
        base = obs.size();
    endtask

    task automatic add(input logic [2:0] ack, input logic [31:0] dread, input logic perr);
        resp_t r;
        r = '{ack, dread, perr};
        scr.push_back(r);
    endtask

    // Reference: walk the frame list the spec implies for this request.
    task automatic model(input logic [1:0] a, input logic ap, input logic rnw,
                         input logic [31:0] wd, input int lim,
                         output int st, output int rt);
        int     i;
        bit     second;
        frame_t f;
        resp_t  r;
        i = 0; second = 0; st = -1; rt = 0;
        expf.delete();
        for (int k = 0; k < 1000 && st < 0; k++) begin
            f = second ? '{2'b11, 1'b0, 1'b1, wd} : '{a, ap, rnw, wd};
            expf.push_back(f);
            r = (base + i < scr.size()) ? scr[base + i] : DEF_RESP;
            i++;
            if (r.ack == 3'b010) begin
                if (rt < lim) rt++;
                else st = 1;
            end else if (r.ack == 3'b100) st = 2;
            else if (r.ack != 3'b001) st = 4;
            else if (f.rnw && r.perr) st = 3;
            else if (ap && rnw && !second) second = 1;
            else begin
                st = 0;
                if (f.rnw) exp_rdata = r.dread;
            end
        end
    endtask

    task automatic run_req(input string tag, input logic [1:0] a, input logic ap,
                           input logic rnw, input logic [31:0] wd,
                           input logic [7:0] cfg, input bit tmo);
        int st, rt, n, lim, nf;
        lim = (cfg == 8'd0) ? 32 : int'(cfg);
        if (tmo) begin st = 5; rt = 0; end
        else model(a, ap, rnw, wd, lim, st, rt);
        @(negedge clk);
        cfg_retries = cfg; req_addr = a; req_apndp = ap; req_rnw = rnw; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) begin
            check({tag, "_ready"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 5000) begin @(negedge clk); n++; end
        if (!rsp_valid) begin
            check({tag, "_rsp"}, 32'(rsp_valid), 32'd1);
            return;
        end
        check({tag, "_status"}, 32'(rsp_status), 32'(st));
        check({tag, "_retries"}, 32'(rsp_retries), 32'(rt));
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
        if (tmo) begin
            check({tag, "_golen"}, 32'((t_fall - t_rise) / 10), 32'd63);
            check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
            check({tag, "_noframe"}, 32'(obs.size() - base), 32'd0);
        end else begin
            nf = obs.size() - base;
            check({tag, "_nframes"}, 32'(nf), 32'(expf.size()));
            for (int i = 0; i < expf.size() && i < nf; i++) begin
                check({tag, "_fhdr"}, 32'({obs[base+i].addr, obs[base+i].apndp, obs[base+i].rnw}),
                      32'({expf[i].addr, expf[i].apndp, expf[i].rnw}));
                check({tag, "_fdata"}, obs[base+i].wdata, expf[i].wdata);
                check({tag, "_godrop"}, 32'(go_after[base+i]), 32'd0);
            end
        end
    endtask

    initial begin : main
        int n, c0, lim_r;
        logic [31:0] d;
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 2'b00; req_apndp = 1'b0;
        req_rnw = 1'b0; req_wdata = 32'd0; cfg_retries = 8'd0;
        #12;
        check("rst_go", 32'(swd_go), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_dwrite", swd_dwrite, 32'd0);
        check("rst_status", 32'(rsp_status), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_idle", 32'(req_ready), 32'd1);

        begin_req(); add(3'b001, 32'h0, 1'b0);
        run_req("dp_wr", 2'b01, 1'b0, 1'b0, 32'hDEADBEEF, 8'd0, 0);

        begin_req(); add(3'b001, 32'h11111111, 1'b0); add(3'b001, 32'h12345678, 1'b0);
        run_req("ap_rd", 2'b11, 1'b1, 1'b1, 32'h0, 8'd0, 0);
        check("ap_rd_val", rsp_rdata, 32'h12345678);

        begin_req(); repeat (5) add(3'b010, 32'h0, 1'b0);
        run_req("wait_exh", 2'b10, 1'b0, 1'b0, 32'h55AA55AA, 8'd3, 0);

        begin_req(); add(3'b010, 32'h0, 1'b0); add(3'b010, 32'h0, 1'b0);
        add(3'b001, 32'h0BADF00D, 1'b0);
        run_req("wait_ok", 2'b00, 1'b0, 1'b1, 32'h0, 8'd3, 0);

        begin_req(); repeat (33) add(3'b010, 32'h0, 1'b0);
        run_req("wait_dflt", 2'b01, 1'b1, 1'b0, 32'h13572468, 8'd0, 0);

        begin_req(); add(3'b001, 32'h77777777, 1'b1);
        run_req("parity", 2'b10, 1'b0, 1'b1, 32'h0, 8'd0, 0);
        begin_req(); add(3'b001, 32'h0, 1'b1);
        run_req("wr_perr", 2'b10, 1'b0, 1'b0, 32'h2468ACE0, 8'd0, 0);
        begin_req(); add(3'b100, 32'h0, 1'b0);
        run_req("fault", 2'b01, 1'b0, 1'b1, 32'h0, 8'd0, 0);
        begin_req(); add(3'b111, 32'h0, 1'b0);
        run_req("proto", 2'b01, 1'b0, 1'b0, 32'h0, 8'd0, 0);
        begin_req(); add(3'b100, 32'h0, 1'b0);
        run_req("ap_fault", 2'b00, 1'b1, 1'b1, 32'h0, 8'd0, 0);

        stuck = 1;
        begin_req();
        run_req("timeout", 2'b11, 1'b0, 1'b1, 32'h0, 8'd0, 1);
        stuck = 0;

        for (int t = 0; t < 40; t++) begin
            begin_req();
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                c0 = $urandom_range(0, 19);
                d = $urandom;
                if (c0 < 12)       add(3'b001, d, 1'b0);
                else if (c0 < 17)  add(3'b010, d, 1'b0);
                else if (c0 == 17) add(3'b100, d, 1'b0);
                else if (c0 == 18) add((($urandom_range(0, 1)) != 0) ? 3'b111 : 3'b000, d, 1'b0);
                else               add(3'b001, d, 1'b1);
            end
            lim_r = $urandom_range(0, 4);
            run_req("rand", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom, 8'(lim_r), 0);
        end

        // Reset while a frame is in flight.
        hold = 1;
        begin_req(); add(3'b001, 32'h0, 1'b0);
        @(negedge clk);
        cfg_retries = 8'd0; req_addr = 2'b01; req_apndp = 1'b0; req_rnw = 1'b0;
        req_wdata = 32'hFEEDFACE; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (swd_idle && n < 50) begin @(negedge clk); n++; end
        check("rst_busy", 32'(swd_idle), 32'd0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_go", 32'(swd_go), 32'd0);
        check("rst_mid_valid", 32'(rsp_valid), 32'd0);
        check("rst_mid_ready", 32'(req_ready), 32'd0);
        c0 = rsp_cnt;
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'd0;
        repeat (4) @(negedge clk);
        check("rst_holdoff", 32'(req_ready), 32'd0);
        check("rst_after_go", 32'(swd_go), 32'd0);
        hold = 0;
        n = 0;
        while (!swd_idle && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        check("rst_ready_back", 32'(req_ready), 32'd1);
        check("rst_no_rsp", 32'(rsp_cnt), 32'(c0));

        begin_req(); add(3'b001, 32'h0, 1'b0); add(3'b001, 32'hA1B2C3D4, 1'b0);
        run_req("post_rst", 2'b10, 1'b1, 1'b1, 32'h0, 8'd0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
